// File: rtl/systolic_result_collector.sv
// Collects drained systolic-array result rows in a row FIFO and streams requantized elements one per cycle.
// Optional feature macro: SYSTOLIC_SAT_COUNT_EN builds the saturation event counter behind sat_count.
module systolic_result_collector #(
    parameter int LANES = 16,
    parameter int DEPTH = 16,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   row_valid,
    input  logic [16*LANES-1:0]    row_in,
    input  logic [3:0]             cols,
    input  logic                   frame_done,
    input  logic [3:0]             shift,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [3:0]             out_row,
    output logic [3:0]             out_col,
    output logic                   out_last,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] rows_stored,
    output logic [15:0]            sat_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = 16 * LANES;
    localparam logic signed [15:0] MAX_V = 16'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
    localparam logic signed [15:0] MIN_V = -MAX_V - 16'sd1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EMIT = 2'd2} state_t;

    // Returns {saturated, value}: arithmetic shift, optional ReLU, then clamp to the signed output range.
    function automatic logic [OUT_W:0] requant(input logic [15:0] lane, input logic [3:0] sh, input logic relu);
        logic signed [15:0] v;
        v = $signed(lane) >>> sh;
        v = (relu && (v < 16'sd0)) ? 16'sd0 : v;
        if (v > MAX_V)      return {1'b1, MAX_V[OUT_W-1:0]};
        else if (v < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
        else                return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic [RW-1:0]    mem_data_r [DEPTH];
    logic [3:0]       mem_cols_r [DEPTH];
    logic [DEPTH-1:0] mem_eof_r;
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r, last_idx_s;
    logic [AW:0]      count_r;
    logic             overflow_r;
    state_t           state_r;
    logic [RW-1:0]    hold_data_r;
    logic [3:0]       hold_cols_r, col_r, last_col_s, col_next_s;
    logic             hold_eof_r;
    logic             out_valid_r, out_last_r;
    logic [OUT_W-1:0] out_data_r;
    logic [3:0]       out_row_r, out_col_r;
    logic             full_s, nonempty_s, wr_en_s, pop_s, fd_fifo_s, fd_hold_s, head_eof_s;
    logic             adv_s, load_out_s;
    logic [OUT_W:0]   next_q_s;

    // FIFO status, frame_done targeting and next-element requantization.
    always_comb begin
        full_s     = count_r[AW];
        nonempty_s = |count_r;
        wr_en_s    = row_valid && !full_s && !clear;
        pop_s      = (state_r == LOAD);
        last_idx_s = wr_ptr_r - AW'(1'b1);
        fd_fifo_s  = frame_done && !wr_en_s && nonempty_s;
        fd_hold_s  = frame_done && !wr_en_s && !nonempty_s && (state_r == EMIT);
        // A frame_done landing on the single entry being popped must reach the holding register too.
        head_eof_s = mem_eof_r[rd_ptr_r] || (fd_fifo_s && (last_idx_s == rd_ptr_r));
        last_col_s = hold_cols_r - 4'd1;
        col_next_s = col_r + 4'd1;
        adv_s      = (state_r == EMIT) && out_ready && (col_r != last_col_s);
        load_out_s = pop_s || adv_s;
        if (pop_s) begin
            next_q_s = requant(mem_data_r[rd_ptr_r][15:0], shift, relu_en);
        end else begin
            next_q_s = requant(hold_data_r[{col_next_s, 4'b0000} +: 16], shift, relu_en);
        end
    end

    // Row storage; stale contents are harmless because pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_data_r[wr_ptr_r] <= row_in;
            mem_cols_r[wr_ptr_r] <= cols;
        end
    end

    // FIFO pointers, occupancy, end-of-frame flags and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            mem_eof_r  <= {DEPTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            mem_eof_r  <= {DEPTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_eof_r[wr_ptr_r] <= frame_done;
                wr_ptr_r            <= wr_ptr_r + AW'(1'b1);
            end
            if (fd_fifo_s) mem_eof_r[last_idx_s] <= 1'b1;
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            if (row_valid && full_s) overflow_r <= 1'b1;
            count_r <= count_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
        end
    end

    // Serializer: IDLE waits for a row, LOAD pops it into the holding register, EMIT streams its lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            hold_data_r <= {RW{1'b0}};
            hold_cols_r <= 4'd0;
            hold_eof_r  <= 1'b0;
            col_r       <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_row_r   <= 4'd0;
            out_col_r   <= 4'd0;
            out_last_r  <= 1'b0;
        end else if (clear) begin
            state_r     <= IDLE;
            hold_data_r <= {RW{1'b0}};
            hold_cols_r <= 4'd0;
            hold_eof_r  <= 1'b0;
            col_r       <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_row_r   <= 4'd0;
            out_col_r   <= 4'd0;
            out_last_r  <= 1'b0;
        end else begin
            if (load_out_s) out_data_r <= next_q_s[OUT_W-1:0];
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (nonempty_s) state_r <= LOAD;
                end
                LOAD: begin
                    hold_data_r <= mem_data_r[rd_ptr_r];
                    hold_cols_r <= mem_cols_r[rd_ptr_r];
                    hold_eof_r  <= head_eof_s;
                    col_r       <= 4'd0;
                    out_col_r   <= 4'd0;
                    out_valid_r <= 1'b1;
                    out_last_r  <= head_eof_s && (mem_cols_r[rd_ptr_r] == 4'd1);
                    state_r     <= EMIT;
                end
                EMIT: begin
                    if (fd_hold_s) begin
                        hold_eof_r <= 1'b1;
                        out_last_r <= (col_r == last_col_s);
                    end
                    if (out_ready) begin
                        if (col_r != last_col_s) begin
                            col_r      <= col_next_s;
                            out_col_r  <= col_next_s;
                            out_last_r <= (hold_eof_r || fd_hold_s) && (col_next_s == last_col_s);
                        end else begin
                            out_valid_r <= 1'b0;
                            out_row_r   <= out_last_r ? 4'd0 : out_row_r + 4'd1;
                            state_r     <= nonempty_s ? LOAD : IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_SAT_COUNT_EN
    logic        out_sat_r;
    logic [15:0] sat_cnt_r;

    // Tracks whether the presented element clamped, and counts accepted clamped elements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat_r <= 1'b0;
            sat_cnt_r <= 16'd0;
        end else if (clear) begin
            out_sat_r <= 1'b0;
            sat_cnt_r <= 16'd0;
        end else begin
            if (load_out_s) out_sat_r <= next_q_s[OUT_W];
            if ((state_r == EMIT) && out_ready && out_sat_r && (sat_cnt_r != 16'hFFFF)) begin
                sat_cnt_r <= sat_cnt_r + 16'd1;
            end
        end
    end

    assign sat_count = sat_cnt_r;
`else
    logic sat_unused_s;
    assign sat_unused_s = next_q_s[OUT_W];
    assign sat_count    = 16'd0;
`endif

    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_row     = out_row_r;
    assign out_col     = out_col_r;
    assign out_last    = out_last_r;
    assign full        = full_s;
    assign overflow    = overflow_r;
    assign rows_stored = count_r;

endmodule
